dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, the memory word width (only 32 supported).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset, synchronous and active-high (1 = reset).
REQ-005 The block SHALL have port req_valid, input, 1 bit, CPU memory request present.
REQ-006 The block SHALL have port req_ready, output, 1 bit, block accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit, 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2 bits, 0 = byte, 1 = half, 2 = word (3 treated as word).
REQ-009 The block SHALL have port req_unsigned, input, 1 bit, zero-extend load (LBU/LHU).
REQ-010 The block SHALL have ports req_addr (ADDR_W) and req_wdata (DATA_W), inputs, byte address and store data (data in low bits).
REQ-011 The block SHALL have ports resp_valid (1), resp_rdata (DATA_W) and resp_err (1), outputs, completion pulse, extended load data, misalignment flag.
REQ-012 The block SHALL have ports dmem_addr (output, ADDR_W), dmem_data (inout, DATA_W) and dmem_wen (output, 1) to the word-wide data RAM.

Function
REQ-013 States SHALL be IDLE, ACCESS, MERGE, DONE; req_ready = 1 only in IDLE.
REQ-014 IDLE with req_valid = 1 SHALL capture all req_* fields and go to ACCESS (or DONE with resp_err = 1 if misaligned).
REQ-015 dmem_addr SHALL be the captured address with bits [1:0] cleared in ACCESS/MERGE, and 0 otherwise.
REQ-016 dmem_data SHALL be driven only while dmem_wen = 1 and SHALL be high-Z otherwise.
REQ-017 Load in ACCESS: the block SHALL register dmem_data at cycle end, go to DONE, and present the selected lane sign- or zero-extended per req_unsigned.
REQ-018 Word store in ACCESS: dmem_wen = 1 with req_wdata, then DONE.
REQ-019 Byte/half store: ACCESS SHALL read the word, MERGE SHALL write the word with only the addressed lanes replaced (dmem_wen = 1), then DONE.
REQ-020 DONE SHALL assert resp_valid for exactly one cycle, then return to IDLE; resp_rdata SHALL be 0 for stores and errors.
REQ-021 Latency from accept edge to resp_valid SHALL be 2 cycles for loads and word stores, 3 for sub-word stores, and 1 for errors.
REQ-022 Misaligned SHALL mean half with addr[0] = 1, or word with addr[1:0] != 0; errored requests SHALL NOT touch memory.
REQ-023 req_valid outside IDLE SHALL be ignored (not queued).

Reset
REQ-024 rst_n = 1 at a clock edge SHALL force IDLE, resp_valid = 0, resp_err = 0, resp_rdata = 0, dmem_wen = 0, and dmem_addr = 0, aborting any access in progress; a pending MERGE write SHALL NOT occur.
REQ-025 While rst_n = 1, req_ready SHALL be 0.

Configuration
REQ-026 With LSU_MISALIGN_CHECK_EN defined, misalignment SHALL be handled per REQ-022.
REQ-027 Without LSU_MISALIGN_CHECK_EN, resp_err SHALL be tied 0, and misaligned addresses SHALL be truncated to natural alignment (half: addr[0] = 0; word: addr[1:0] = 0) and executed normally.

Structure
REQ-028 Package lsu_pkg SHALL hold the state enum, size encodings (SZ_B, SZ_H, SZ_W), and the lane-mask function.
REQ-029 Combinational sub-module lsu_align SHALL perform load lane extract/extend and store lane merge; the FSM stays in dmem_lsu.

Verification
REQ-030 LW addr 0x10, RAM[0x10] = 0xDEADBEEF -> resp_valid 2 cycles after accept, rdata 0xDEADBEEF, err 0.
REQ-031 LB addr 0x13, word 0x80FF_0000 -> rdata 0xFFFFFF80; LBU at same address -> 0x00000080.
REQ-032 SH 0xABCD to 0x22, word 0x11223344 -> one read, one write, RAM = 0xABCD3344, resp_valid 3 cycles after accept.
REQ-033 LW addr 0x06 -> with LSU_MISALIGN_CHECK_EN: err 1 after 1 cycle, dmem_wen never 1; without it: reads 0x04.
REQ-034 Reset asserted during MERGE of SB -> no write, outputs at reset values, RAM unchanged, req_ready = 1 one cycle after reset release.
REQ-035 req_valid held high for back-to-back SW 0x00, SW 0x04 -> second accepted only after DONE; both written; dmem_data is Z in every non-write cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the data-memory load/store unit.
//   - FSM state encoding (IDLE, ACCESS, MERGE, DONE)
//   - access size encoding (SZ_B, SZ_H, SZ_W); the raw 2-bit code 3 is folded onto SZ_W
//   - helpers: size normalisation, byte-lane mask, misalignment test, address truncation
package lsu_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_MERGE  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    function automatic lsu_size_e norm_size(input logic [1:0] sz);
        return (sz == 2'd3) ? SZ_W : lsu_size_e'(sz);
    endfunction

    // Byte lanes of the 32-bit word touched by an access of size sz at offset lo.
    function automatic logic [3:0] lane_mask(input lsu_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 4'b0001 << lo;
            SZ_H:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input lsu_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_H:    return lo[0];
            SZ_W:    return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Force the low address bits to the natural alignment of the access size.
    function automatic logic [1:0] align_lo(input lsu_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_H:    return {lo[1], 1'b0};
            SZ_W:    return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   size, addr_lo, is_unsigned : captured access attributes
//   rd_word                    : word read from the data RAM
//   wdata                      : store data, right-justified
//   ld_data                    : selected load lane, sign- or zero-extended
//   st_word                    : rd_word with the addressed lanes replaced by wdata
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] wdata_rep;
    logic [3:0]  mask;

    always_comb begin
        ld_byte = rd_word[{addr_lo, 3'b000} +: 8];
        ld_half = rd_word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    ld_data = {{24{ld_byte[7] & ~is_unsigned}}, ld_byte};
            SZ_H:    ld_data = {{16{ld_half[15] & ~is_unsigned}}, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    // Replicate the store data across the word so every candidate lane already
    // holds the right bytes; the mask then picks which lanes replace RAM data.
    always_comb begin
        case (size)
            SZ_B:    wdata_rep = {4{wdata[7:0]}};
            SZ_H:    wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
        mask    = lane_mask(size, addr_lo);
        st_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) st_word[8*i +: 8] = wdata_rep[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: CPU load/store unit in front of a word-wide, single-port data RAM.
// Loads read one word; word stores write one word; byte/half stores do a
// read-modify-write (read in ACCESS, merged write in MERGE).
//
// Build option: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word
// accesses with resp_err (no memory access). Without it resp_err stays 0 and
// misaligned addresses are truncated to natural alignment.
//
// Ports:
//   clk, rst_n            : clock; synchronous active-high reset (1 = reset)
//   req_valid / req_ready : request handshake, ready only in IDLE
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   resp_valid, resp_rdata, resp_err : one-cycle completion pulse and result
//   dmem_addr, dmem_data, dmem_wen   : word RAM port; dmem_data driven only while writing
//
// state  | meaning
// IDLE   | ready for a request, captures it on req_valid
// ACCESS | RAM addressed; load/RMW read captured, or word store written
// MERGE  | sub-word store: merged word written back
// DONE   | schedules the response pulse, returns to IDLE
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dmem_addr,
    inout  wire  [DATA_W-1:0] dmem_data,
    output logic              dmem_wen
);

    logic [1:0]        state;
    logic              we_q;
    logic              uns_q;
    logic              err_q;
    lsu_size_e         size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;

    lsu_size_e         size_n;
    logic              req_misaligned;
    logic [ADDR_W-1:0] addr_eff;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_word;
    logic [DATA_W-1:0] wr_data;
    logic              sub_word;

    assign size_n   = norm_size(req_size);
    assign sub_word = (size_q != SZ_W);

`ifdef LSU_MISALIGN_CHECK_EN
    assign req_misaligned = misaligned(size_n, req_addr[1:0]);
    assign addr_eff       = req_addr;
`else
    assign req_misaligned = 1'b0;
    assign addr_eff       = {req_addr[ADDR_W-1:2], align_lo(size_n, req_addr[1:0])};
`endif

    assign req_ready = (state == ST_IDLE) && !rst_n;

    // Gated by reset so a MERGE write cannot land in the cycle reset is applied.
    assign dmem_wen  = !rst_n &&
                       (((state == ST_ACCESS) && we_q && !sub_word) || (state == ST_MERGE));
    assign dmem_addr = ((state == ST_ACCESS) || (state == ST_MERGE)) ?
                       {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign wr_data   = (state == ST_MERGE) ? st_word : wdata_q;
    assign dmem_data = dmem_wen ? wr_data : 'z;

    lsu_align u_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .rd_word     (word_q),
        .wdata       (wdata_q),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= SZ_W;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        size_q  <= size_n;
                        addr_q  <= addr_eff;
                        wdata_q <= req_wdata;
                        err_q   <= req_misaligned;
                        state   <= req_misaligned ? ST_DONE : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    word_q <= dmem_data;
                    state  <= (we_q && sub_word) ? ST_MERGE : ST_DONE;
                end
                ST_MERGE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b1;
                    resp_err   <= err_q;
                    resp_rdata <= (we_q || err_q) ? '0 : ld_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: self-checking bench for dmem_lsu with a word RAM model on the
// tri-state data bus. Directed vector table, hand-written multi-cycle sequences
// (reset during MERGE, back-to-back stores) and random traffic checked against
// a byte-array reference model. Honours LSU_MISALIGN_CHECK_EN.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    wire  [31:0] dmem_data;

    logic [31:0] ram [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_word = '0;
    logic [7:0]  mb [0:255];

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    bit mon_en = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dmem_addr    (dmem_addr),
        .dmem_data    (dmem_data),
        .dmem_wen     (dmem_wen)
    );

    assign dmem_data = dmem_wen ? 32'hzzzz_zzzz : ram[dmem_addr[7:2]];

    always @(posedge clk) begin
        if (dmem_wen) begin
            ram[dmem_addr[7:2]] <= dmem_data;
            wr_cnt <= wr_cnt + 1;
        end else if (pre_en) begin
            ram[pre_idx] <= pre_word;
        end
    end

    // Whenever the LSU is not writing, the bus must carry exactly the RAM's read data.
    always @(negedge clk) begin
        if (mon_en && !dmem_wen) begin
            checks++;
            if (dmem_data !== ram[dmem_addr[7:2]]) begin
                errors++;
                $display("FAIL bus_release: dmem_data=%h expected ram %h at addr %h",
                         dmem_data, ram[dmem_addr[7:2]], dmem_addr);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] w);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = addr[7:2]; pre_word = w;
        @(negedge clk);
        pre_en = 1'b0;
        for (int b = 0; b < 4; b++) mb[{addr[7:2], 2'b00} + 8'(b)] = w[8*b +: 8];
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        logic [31:0] v;
        for (int b = 0; b < 4; b++) v[8*b +: 8] = mb[{addr[7:2], 2'b00} + 8'(b)];
        return v;
    endfunction

    // Reference: byte-addressed memory, expected result, latency and write count.
    task automatic model_req(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er, output int lat, output int wr);
        int nb;
        int a;
        logic [31:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a  = int'(addr[7:0]);
        rd = '0; er = 1'b0; wr = 0; lat = 2;
        if (a % nb != 0) begin
`ifdef LSU_MISALIGN_CHECK_EN
            er = 1'b1; lat = 1;
            return;
`else
            a = a - (a % nb);
`endif
        end
        if (we) begin
            for (int b = 0; b < nb; b++) mb[a + b] = wd[8*b +: 8];
            lat = (nb == 4) ? 2 : 3;
            wr  = 1;
        end else begin
            v = '0;
            for (int b = 0; b < nb; b++) v = v | (32'(mb[a + b]) << (8*b));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            rd = v;
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat, output int wr);
        int w0;
        int n;
        rd = '0; er = 1'b0; lat = -1; wr = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        w0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i; rd = resp_rdata; er = resp_err;
                break;
            end
        end
        if (lat < 0) begin
            check({tag, "_resp_timeout"}, 32'(resp_valid), 32'd1);
            return;
        end
        @(negedge clk);
        check({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
        wr = wr_cnt - w0;
    endtask

    typedef struct {
        bit          pre;
        logic [31:0] pre_w;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vt [12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, m_rd, w_a, w_b;
        logic        er, m_er;
        int          lat, wr, m_lat, m_wr, w0, hit;
        logic        we, uns;
        logic [1:0]  sz;
        logic [31:0] addr, wd;

        vt[0]  = '{1, 32'hDEAD_BEEF, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 32'hDEAD_BEEF};
        vt[1]  = '{1, 32'h80FF_0000, 0, 2'd0, 0, 32'h13, 32'h0, 32'hFFFF_FF80, 0, 2, 0, 32'h80FF_0000};
        vt[2]  = '{0, 32'h0,         0, 2'd0, 1, 32'h13, 32'h0, 32'h0000_0080, 0, 2, 0, 32'h80FF_0000};
        vt[3]  = '{1, 32'h1122_3344, 1, 2'd1, 0, 32'h22, 32'h0000_ABCD, 32'h0, 0, 3, 1, 32'hABCD_3344};
        vt[4]  = '{0, 32'h0,         0, 2'd1, 0, 32'h22, 32'h0, 32'hFFFF_ABCD, 0, 2, 0, 32'hABCD_3344};
        vt[5]  = '{0, 32'h0,         0, 2'd1, 1, 32'h22, 32'h0, 32'h0000_ABCD, 0, 2, 0, 32'hABCD_3344};
        vt[6]  = '{0, 32'h0,         1, 2'd0, 0, 32'h21, 32'hFFFF_FF5A, 32'h0, 0, 3, 1, 32'hABCD_5A44};
        vt[7]  = '{0, 32'h0,         0, 2'd0, 0, 32'h20, 32'h0, 32'h0000_0044, 0, 2, 0, 32'hABCD_5A44};
        vt[8]  = '{0, 32'h0,         0, 2'd1, 0, 32'h20, 32'h0, 32'h0000_5A44, 0, 2, 0, 32'hABCD_5A44};
        vt[9]  = '{1, 32'h0,         1, 2'd3, 0, 32'h24, 32'h1234_5678, 32'h0, 0, 2, 1, 32'h1234_5678};
`ifdef LSU_MISALIGN_CHECK_EN
        vt[10] = '{1, 32'hCAFE_F00D, 0, 2'd2, 0, 32'h06, 32'h0, 32'h0, 1, 1, 0, 32'hCAFE_F00D};
        vt[11] = '{0, 32'h0,         1, 2'd1, 0, 32'h23, 32'h7777, 32'h0, 1, 1, 0, 32'hABCD_5A44};
`else
        vt[10] = '{1, 32'hCAFE_F00D, 0, 2'd2, 0, 32'h06, 32'h0, 32'hCAFE_F00D, 0, 2, 0, 32'hCAFE_F00D};
        vt[11] = '{0, 32'h0,         1, 2'd1, 0, 32'h23, 32'h7777, 32'h0, 0, 3, 1, 32'h7777_5A44};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready",  32'(req_ready),  32'd0);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_err",    32'(resp_err),   32'd0);
        check("rst_rdata",  resp_rdata,      32'd0);
        check("rst_wen",    32'(dmem_wen),   32'd0);
        check("rst_addr",   dmem_addr,       32'd0);
        for (int i = 0; i < 64; i++) poke(32'(i * 4), $urandom);
        mon_en = 1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            if (vt[i].pre) poke({vt[i].addr[31:2], 2'b00}, vt[i].pre_w);
            model_req(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, m_rd, m_er, m_lat, m_wr);
            do_req($sformatf("vec%0d", i), vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd,
                   rd, er, lat, wr);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            check($sformatf("vec%0d_writes", i), 32'(wr), 32'(vt[i].exp_wr));
            check($sformatf("vec%0d_mem", i), ram[vt[i].addr[7:2]], vt[i].exp_mem);
        end

        // Reset during the MERGE cycle of a byte store
        poke(32'h30, 32'h1111_1111);
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h31; req_wdata = 32'hEE;
        check("mrg_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mrg_wen_before_rst", 32'(dmem_wen), 32'd1);
        check("mrg_addr", dmem_addr, 32'h30);
        rst_n = 1'b1;
        #1;
        check("mrg_wen_gated", 32'(dmem_wen), 32'd0);
        @(negedge clk);
        check("mrg_rst_rvalid", 32'(resp_valid), 32'd0);
        check("mrg_rst_err",    32'(resp_err),   32'd0);
        check("mrg_rst_rdata",  resp_rdata,      32'd0);
        check("mrg_rst_wen",    32'(dmem_wen),   32'd0);
        check("mrg_rst_addr",   dmem_addr,       32'd0);
        check("mrg_rst_ready",  32'(req_ready),  32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrg_ready_after", 32'(req_ready), 32'd1);
        check("mrg_ram", ram[12], 32'h1111_1111);
        check("mrg_no_write", 32'(wr_cnt - w0), 32'd0);
        repeat (2) @(negedge clk);
        check("mrg_no_resp", 32'(resp_valid), 32'd0);

        // Back-to-back word stores with req_valid held high
        w_a = 32'hA5A5_0001; w_b = 32'h5A5A_0002;
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = w_a;
        check("b2b_ready0", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_addr = 32'h4; req_wdata = w_b;
        @(negedge clk);
        check("b2b_busy1", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("b2b_busy2", 32'(req_ready), 32'd0);
        check("b2b_noresp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("b2b_ready3", 32'(req_ready), 32'd1);
        check("b2b_resp1", 32'(resp_valid), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        hit = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                hit = i;
                break;
            end
        end
        check("b2b_resp2_latency", 32'(hit), 32'd2);
        check("b2b_ram0", ram[0], w_a);
        check("b2b_ram1", ram[1], w_b);
        check("b2b_writes", 32'(wr_cnt - w0), 32'd2);
        model_req(1'b1, 2'd2, 1'b0, 32'h0, w_a, m_rd, m_er, m_lat, m_wr);
        model_req(1'b1, 2'd2, 1'b0, 32'h4, w_b, m_rd, m_er, m_lat, m_wr);

        // Random traffic against the byte-array model
        for (int t = 0; t < 300; t++) begin
            we   = 1'($urandom);
            sz   = 2'($urandom);
            uns  = 1'($urandom);
            addr = 32'($urandom_range(0, 255));
            wd   = $urandom;
            model_req(we, sz, uns, addr, wd, m_rd, m_er, m_lat, m_wr);
            do_req("rnd", we, sz, uns, addr, wd, rd, er, lat, wr);
            check($sformatf("rnd%0d_rdata", t),   rd,        m_rd);
            check($sformatf("rnd%0d_err", t),     32'(er),   32'(m_er));
            check($sformatf("rnd%0d_latency", t), 32'(lat),  32'(m_lat));
            check($sformatf("rnd%0d_writes", t),  32'(wr),   32'(m_wr));
            check($sformatf("rnd%0d_mem", t),     ram[addr[7:2]], model_word(addr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
